// File: rtl/ripple_add_seq_if.sv
// Operand/result handshake bundle for ripple_add_seq.
// The ovf signal is present only when RIPPLE_ADD_SEQ_OVF_EN is defined.
interface ripple_add_seq_if #(
    parameter int NBYTES = 4
);
    logic                  start_valid;
    logic                  start_ready;
    logic [8*NBYTES-1:0]   a;
    logic [8*NBYTES-1:0]   b;
    logic                  cin;
    logic                  busy;
    logic                  done_valid;
    logic                  done_ready;
    logic [8*NBYTES-1:0]   result;
    logic                  cout;
`ifdef RIPPLE_ADD_SEQ_OVF_EN
    logic                  ovf;
`endif

    modport master (
        output start_valid, a, b, cin, done_ready,
        input  start_ready, busy, done_valid, result, cout
`ifdef RIPPLE_ADD_SEQ_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  start_valid, a, b, cin, done_ready,
        output start_ready, busy, done_valid, result, cout
`ifdef RIPPLE_ADD_SEQ_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/ripple_add_seq.sv
// Byte-serial wide adder: one shared 8-bit bitripple, LSB byte first, carry held between cycles.
// Optional signed-overflow output enabled by RIPPLE_ADD_SEQ_OVF_EN.
module bitripple (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic [8:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign cout = c[8];
endmodule

module ripple_add_seq #(
    parameter int NBYTES = 4
) (
    input  logic             clk,
    input  logic             rst,
    ripple_add_seq_if.slave  bus
);
    localparam int W     = 8 * NBYTES;
    localparam int IDX_W = $clog2(NBYTES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [W-1:0]       a_reg_q, a_reg_d;
    logic [W-1:0]       b_reg_q, b_reg_d;
    logic               carry_reg_q, carry_reg_d;
    logic [W-1:0]       result_reg_q, result_reg_d;

    logic [7:0]         add_a, add_b, add_sum;
    logic               add_cout;
    logic               last_byte;

    assign add_a     = a_reg_q[8*idx_q +: 8];
    assign add_b     = b_reg_q[8*idx_q +: 8];
    assign last_byte = (idx_q == IDX_W'(NBYTES - 1));

    bitripple u_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_reg_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

`ifdef RIPPLE_ADD_SEQ_OVF_EN
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        a_reg_d      = a_reg_q;
        b_reg_d      = b_reg_q;
        carry_reg_d  = carry_reg_q;
        result_reg_d = result_reg_q;
`ifdef RIPPLE_ADD_SEQ_OVF_EN
        ovf_d        = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start_valid) begin
                    a_reg_d     = bus.a;
                    b_reg_d     = bus.b;
                    carry_reg_d = bus.cin;
                    idx_d       = '0;
`ifdef RIPPLE_ADD_SEQ_OVF_EN
                    ovf_d       = 1'b0;
`endif
                    state_d     = RUN;
                end
            end
            RUN: begin
                result_reg_d[8*idx_q +: 8] = add_sum;
                carry_reg_d                = add_cout;
                if (last_byte) begin
                    state_d = DONE;
`ifdef RIPPLE_ADD_SEQ_OVF_EN
                    // Signed overflow: operands agree in sign, result sign differs.
                    ovf_d = (a_reg_q[W-1] == b_reg_q[W-1]) && (add_sum[7] != a_reg_q[W-1]);
`endif
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (bus.done_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            a_reg_q      <= '0;
            b_reg_q      <= '0;
            carry_reg_q  <= 1'b0;
            result_reg_q <= '0;
`ifdef RIPPLE_ADD_SEQ_OVF_EN
            ovf_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            a_reg_q      <= a_reg_d;
            b_reg_q      <= b_reg_d;
            carry_reg_q  <= carry_reg_d;
            result_reg_q <= result_reg_d;
`ifdef RIPPLE_ADD_SEQ_OVF_EN
            ovf_q        <= ovf_d;
`endif
        end
    end

    assign bus.start_ready = (state_q == IDLE);
    assign bus.busy        = (state_q == RUN) || (state_q == DONE);
    assign bus.done_valid  = (state_q == DONE);
    assign bus.result      = result_reg_q;
    assign bus.cout        = carry_reg_q;
`ifdef RIPPLE_ADD_SEQ_OVF_EN
    assign bus.ovf         = ovf_q;
`endif
endmodule
